// File: rtl/pipe_core.sv
// Five-stage in-order core (IF/ID/EX/MEM/WB) with a 16-entry register file,
// EX/MEM and MEM/WB forwarding, load-use stalls and pause/step gating.
module pipe_core #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 8,
  parameter int DADDR_W = 8,
  parameter int RET_W   = 32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               PAUSE,
  input  logic               STEP,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [15:0]        imem_data,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic [3:0]         dbg_ra,
  output logic [DATA_W-1:0]  dbg_rd,
  output logic [RET_W-1:0]   retired
);

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_LW   = 4'd8;
  localparam logic [3:0] OP_SW   = 4'd9;

  // adv is the single pipeline enable: every stage register, the register-file
  // write, the store strobe and the retired counter move only when adv=1.
  logic adv;
  assign adv = ~PAUSE | STEP;

  logic [PC_W-1:0]   pc;
  logic              ifid_v;
  logic [15:0]       ifid_insn;
  logic              de_v, de_wen, de_lw, de_sw, de_imm_sel;
  logic [3:0]        de_op, de_ra, de_rb, de_rd;
  logic [DATA_W-1:0] de_a, de_b, de_imm;
  logic              em_v, em_wen, em_lw, em_sw;
  logic [3:0]        em_rd;
  logic [DATA_W-1:0] em_res, em_sd;
  logic              mw_v, mw_wen;
  logic [3:0]        mw_rd;
  logic [DATA_W-1:0] mw_val;
  logic [DATA_W-1:0] rf [16];

  // Decode
  logic [3:0]        id_op, id_ra, id_rb, id_rd;
  logic              id_alu, id_addi, id_lw, id_sw, id_use_a, id_use_b, id_wen;
  logic [DATA_W-1:0] id_imm, id_a, id_b;
  logic              wb_we, ld_hz;

  always_comb begin
    id_op    = ifid_insn[15:12];
    id_alu   = (id_op >= OP_ADD) && (id_op <= OP_SLT);
    id_addi  = (id_op == OP_ADDI);
    id_lw    = (id_op == OP_LW);
    id_sw    = (id_op == OP_SW);
    id_ra    = (id_lw || id_sw) ? ifid_insn[7:4] : ifid_insn[11:8];
    id_rb    = id_sw ? ifid_insn[11:8] : ifid_insn[7:4];
    id_rd    = id_alu ? ifid_insn[3:0] : ifid_insn[11:8];
    id_use_a = id_alu || id_addi || id_lw || id_sw;
    id_use_b = id_alu || id_sw;
    id_wen   = id_alu || id_addi || id_lw;
    id_imm   = id_addi ? DATA_W'($signed(ifid_insn[7:0])) : DATA_W'(ifid_insn[3:0]);
  end

  assign wb_we = adv && mw_v && mw_wen && (mw_rd != 4'd0);

  // Register read with write-through from the WB stage; R0 is always zero.
  assign id_a = (id_ra == 4'd0) ? '0 : (wb_we && (mw_rd == id_ra)) ? mw_val : rf[id_ra];
  assign id_b = (id_rb == 4'd0) ? '0 : (wb_we && (mw_rd == id_rb)) ? mw_val : rf[id_rb];

  assign ld_hz = ifid_v && de_v && de_lw && (de_rd != 4'd0) &&
                 ((id_use_a && (id_ra == de_rd)) || (id_use_b && (id_rb == de_rd)));

  // Execute with forwarding; a load in EX/MEM is never a source because the
  // load-use stall keeps its consumer one stage further back.
  logic              em_fwd, mw_fwd;
  logic [DATA_W-1:0] ex_a, ex_b, ex_opb, ex_res;

  always_comb begin
    em_fwd = em_v && em_wen && !em_lw && (em_rd != 4'd0);
    mw_fwd = mw_v && mw_wen && (mw_rd != 4'd0);
    ex_a   = (em_fwd && (em_rd == de_ra)) ? em_res :
             (mw_fwd && (mw_rd == de_ra)) ? mw_val : de_a;
    ex_b   = (em_fwd && (em_rd == de_rb)) ? em_res :
             (mw_fwd && (mw_rd == de_rb)) ? mw_val : de_b;
    ex_opb = de_imm_sel ? de_imm : ex_b;
    case (de_op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: ex_res = ex_a + ex_opb;
      OP_SUB: ex_res = ex_a - ex_opb;
      OP_AND: ex_res = ex_a & ex_opb;
      OP_OR:  ex_res = ex_a | ex_opb;
      OP_XOR: ex_res = ex_a ^ ex_opb;
      OP_SLT: ex_res = DATA_W'($signed(ex_a) < $signed(ex_opb));
      default: ex_res = '0;
    endcase
  end

  assign imem_addr  = pc;
  assign dmem_addr  = em_res[DADDR_W-1:0];
  assign dmem_wdata = em_sd;
  assign dmem_we    = adv && em_v && em_sw;
  assign dbg_rd     = (dbg_ra == 4'd0) ? '0 : rf[dbg_ra];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc        <= '0;
      ifid_v    <= 1'b0;
      ifid_insn <= '0;
    end else if (adv && !ld_hz) begin
      pc        <= pc + PC_W'(1);
      ifid_v    <= 1'b1;
      ifid_insn <= imem_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      de_v <= 1'b0; de_wen <= 1'b0; de_lw <= 1'b0; de_sw <= 1'b0; de_imm_sel <= 1'b0;
      de_op <= '0; de_ra <= '0; de_rb <= '0; de_rd <= '0;
      de_a <= '0; de_b <= '0; de_imm <= '0;
    end else if (adv) begin
      de_v       <= ifid_v && !ld_hz;
      de_wen     <= id_wen;
      de_lw      <= id_lw;
      de_sw      <= id_sw;
      de_imm_sel <= id_addi || id_lw || id_sw;
      de_op      <= id_op;
      de_ra      <= id_ra;
      de_rb      <= id_rb;
      de_rd      <= id_rd;
      de_a       <= id_a;
      de_b       <= id_b;
      de_imm     <= id_imm;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      em_v <= 1'b0; em_wen <= 1'b0; em_lw <= 1'b0; em_sw <= 1'b0;
      em_rd <= '0; em_res <= '0; em_sd <= '0;
      mw_v <= 1'b0; mw_wen <= 1'b0; mw_rd <= '0; mw_val <= '0;
    end else if (adv) begin
      em_v   <= de_v;
      em_wen <= de_wen;
      em_lw  <= de_lw;
      em_sw  <= de_sw;
      em_rd  <= de_rd;
      em_res <= ex_res;
      em_sd  <= ex_b;
      mw_v   <= em_v;
      mw_wen <= em_wen;
      mw_rd  <= em_rd;
      mw_val <= em_lw ? dmem_rdata : em_res;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      retired <= '0;
    end else begin
      if (wb_we) rf[mw_rd] <= mw_val;
      if (adv && mw_v) retired <= retired + RET_W'(1);
    end
  end

endmodule

// File: doc/pipe_core.md
Name: pipe_core

Overview:
- Parametrised 5-stage in-order pipelined core (IF/ID/EX/MEM/WB) with an internal 16-entry register file and ALU.
- Adds EX/MEM and MEM/WB forwarding, load-use stall insertion, a hardwired-zero R0, a retired-instruction counter and a debug register read port for the VGA register display.
- Instruction and data memories sit outside the block and connect through combinational-read ports.
- Pause/step gating is built in; STEP arrives already debounced as a one-cycle pulse.

Parameters:
- DATA_W, 16, datapath and register width (≥8).
- PC_W, 8, instruction address width.
- DADDR_W, 8, data address width; address = ALU result[DADDR_W-1:0].
- RET_W, 32, retired counter width.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- PAUSE  in  1  1 = hold pipeline except on STEP.
- STEP  in  1  one-cycle advance pulse, honoured only while PAUSE=1.
- imem_addr  out  PC_W  = PC.
- imem_data  in  16  instruction at imem_addr, same cycle.
- dmem_addr  out  DADDR_W  MEM-stage address.
- dmem_we  out  1  store strobe, valid for one advancing cycle.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data at dmem_addr, same cycle.
- dbg_ra  in  4  debug register select.
- dbg_rd  out  DATA_W  R[dbg_ra], combinational; reads 0 for dbg_ra=0.
- retired  out  RET_W  count of non-bubble instructions leaving WB.

Behaviour:
- Reset (async assert, sync release): PC=0; all pipeline registers hold NOP; registers R1..R15=0; retired=0; dmem_we=0.
- ISA encoding, op=insn[15:12]:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT (signed, result 1/0): R[insn[3:0]] <= R[insn[11:8]] op R[insn[7:4]].
  - 7 ADDI: R[11:8] <= R[11:8] + sext(insn[7:0]) to DATA_W.
  - 8 LW: R[11:8] <= mem[R[7:4] + zext(insn[3:0])].
  - 9 SW: mem[R[7:4] + zext(insn[3:0])] <= R[11:8].
  - 10-15 execute as NOP.
- Arithmetic is modulo 2^DATA_W; no overflow flag.
- Writes to R0 are discarded; R0 always reads 0, including on forwarding paths.
- adv = ~PAUSE | (PAUSE & STEP). When adv=0: all state holds, dmem_we=0, no register write, retired holds.
- Register write happens in WB on an adv edge. ID reads of the register being written in the same cycle return the new value (write-through).
- Forwarding for each EX operand, in priority order:
  1. EX/MEM non-load result whose dest matches the source (dest≠0).
  2. MEM/WB writeback value whose dest matches.
  3. ID/EX register value.
- SW store data is forwarded by the same rules.
- Load-use hazard: ID/EX holds an LW with dest≠0, and the instruction in ID sources that register (any used operand, including SW data). On adv:
  - PC and IF/ID hold.
  - A bubble enters ID/EX.
  - Penalty is exactly one advancing cycle.
- PC increments by 1 per non-stalled adv and wraps 2^PC_W-1 → 0.
- retired increments on adv when the MEM/WB entry is non-bubble (any op 0-15 fetched, excluding inserted bubbles and reset NOPs); wraps at 2^RET_W.
- Bubble tracking uses a valid bit per stage. Reset clears all valid bits. The first fetched instruction sets the IF/ID valid bit.
- A STEP pulse while PAUSE=0 has no extra effect.
- Reset asserted mid-stall or mid-store clears immediately; no dmem_we glitch after RST_N falls.

Test Plan:
- Forwarding: ADDI R1,5; ADDI R2,3; ADD R1,R2→R3; SUB R3,R1→R4 back-to-back → R3=8, R4=3, no stall cycles; retired=4 after 8 cycles from reset.
- Load-use: data mem[4]=0x1234; LW R5,[R0+4]; ADD R5,R5→R6 → exactly one bubble; R6=0x2468; PC advances one less over that interval.
- Store/load forwarding: ADDI R7,-1; SW R7,[R0+2]; LW R8,[R0+2] → dmem_we pulse with addr 2 and data 0xFFFF; R8=0xFFFF.
- R0: ADDI R0,9; ADD R0,R0→R9 → dbg_rd(0)=0, R9=0.
- Pause/step: PAUSE=1 for 20 cycles → PC, retired and dbg values frozen; 3 STEP pulses → PC+3.
- Reset and width: assert RST_N low mid-program → PC=0, retired=0, R1..R15=0 immediately. With DATA_W=8: SLT R1(0x80),R2(0x01) → 1; ADDI R1,0x7F from 0x01 → 0x80.
